// File: rtl/tinyproc_pkg.sv
// rtl/tinyproc_pkg.sv - shared tinyproc widths, frame marker, loader state and write-port types
package tinyproc_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int INSTR_WIDTH = 10;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [INSTR_WIDTH-1:0] wdata;
  } imem_wr_t;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction RAM writer, gates core execution
module program_loader
  import tinyproc_pkg::*;
#(
  parameter int         ADDR_WIDTH  = tinyproc_pkg::ADDR_WIDTH,
  parameter int         INSTR_WIDTH = tinyproc_pkg::INSTR_WIDTH,
  parameter logic [7:0] SYNC_BYTE   = tinyproc_pkg::SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_run,
  output logic                   load_done,
  output logic                   load_error
);

  // Word counter must hold 2**ADDR_WIDTH (LEN=0) as well as any 8-bit LEN value.
  localparam int CW = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
  localparam logic [7:0] SPARE_MASK = 8'(8'hFF << (INSTR_WIDTH - 8));

  loader_state_t           state;
  imem_wr_t                wr_q;
  logic [CW-1:0]           words_left;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [7:0]              sum;
  logic [INSTR_WIDTH-9:0]  hi_q;

  logic       accept;
  logic [7:0] sum_next;

  assign accept   = in_valid && in_ready;
  assign sum_next = sum + in_data;

  assign imem_we    = wr_q.we;
  assign imem_addr  = wr_q.addr;
  assign imem_wdata = wr_q.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_q       <= '0;
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      words_left <= '0;
      addr       <= '0;
      sum        <= '0;
      hi_q       <= '0;
    end else begin
      wr_q.we   <= 1'b0;
      load_done <= 1'b0;
      in_ready  <= 1'b1;
      if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (in_data == SYNC_BYTE) begin
              state      <= LEN;
              cpu_run    <= 1'b0;
              load_error <= 1'b0;
            end
          end
          LEN: begin
            words_left <= (in_data == 8'd0) ? CW'(1 << ADDR_WIDTH) : CW'(in_data);
            addr       <= '0;
            sum        <= in_data;
            state      <= HI;
          end
          HI: begin
            if ((in_data & SPARE_MASK) != 8'd0) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              hi_q  <= in_data[INSTR_WIDTH-9:0];
              sum   <= sum_next;
              state <= LO;
            end
          end
          LO: begin
            // The write cycle doubles as the stream bubble, so in_ready drops for it.
            wr_q.we    <= 1'b1;
            wr_q.addr  <= addr;
            wr_q.wdata <= {hi_q, in_data};
            addr       <= addr + ADDR_WIDTH'(1);
            words_left <= words_left - CW'(1);
            sum        <= sum_next;
            in_ready   <= 1'b0;
            state      <= (words_left == CW'(1)) ? CSUM : HI;
          end
          CSUM: begin
            if (sum_next == 8'd0) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_run   <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
